// File: rtl/sme_feeder.sv
// Upstream feeder for the SME string-matching engine: buffers framed string/pattern
// records, replays each as an unbroken burst, and returns tagged match results.
module sme_feeder #(
    parameter int unsigned MAX_STR_LEN = 32,
    parameter int unsigned MAX_PAT_LEN = 8,
    parameter int unsigned ID_W        = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_data,
    input  logic            in_type,
    input  logic            in_last,
    output logic [7:0]      chardata,
    output logic            isstring,
    output logic            ispattern,
    input  logic            sme_valid,
    input  logic            sme_match,
    input  logic [4:0]      sme_match_index,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_match,
    output logic [4:0]      res_index,
    output logic [ID_W-1:0] res_str_id,
    output logic [ID_W-1:0] res_pat_id,
    output logic            ovf
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned LEN_W  = $clog2(MAX_STR_LEN + 1);
    localparam int unsigned AW     = (MAX_STR_LEN > 1) ? $clog2(MAX_STR_LEN) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_WAIT,
        ST_RESULT
    } state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic                type_q, type_d;
    logic [ID_W-1:0]     str_id_q, str_id_d;
    logic [ID_W-1:0]     pat_id_q, pat_id_d;
    logic                in_ready_q, in_ready_d;
    logic [DATA_W-1:0]   chardata_q, chardata_d;
    logic                isstring_q, isstring_d;
    logic                ispattern_q, ispattern_d;
    logic                res_valid_q, res_valid_d;
    logic                res_match_q, res_match_d;
    logic [IDX_W-1:0]    res_index_q, res_index_d;
    logic [ID_W-1:0]     res_str_id_q, res_str_id_d;
    logic [ID_W-1:0]     res_pat_id_q, res_pat_id_d;
    logic                ovf_q, ovf_d;

    logic [DATA_W-1:0]   mem_q [MAX_STR_LEN];
    logic                we_c;
    logic [AW-1:0]       waddr_c;
    logic                accept_c;
    logic [LEN_W-1:0]    limit_c;
    logic                play_last_c;

    assign accept_c    = in_valid && in_ready_q;
    assign limit_c     = type_q ? LEN_W'(MAX_PAT_LEN) : LEN_W'(MAX_STR_LEN);
    assign play_last_c = (ptr_q == AW'(len_q - LEN_W'(1)));

    // Record buffer; contents are only meaningful up to len_q.
    always_ff @(posedge clk) begin
        if (we_c) begin
            mem_q[waddr_c] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            ptr_q        <= '0;
            type_q       <= 1'b0;
            str_id_q     <= '0;
            pat_id_q     <= '0;
            in_ready_q   <= 1'b0;
            chardata_q   <= '0;
            isstring_q   <= 1'b0;
            ispattern_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            res_match_q  <= 1'b0;
            res_index_q  <= '0;
            res_str_id_q <= '0;
            res_pat_id_q <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            ptr_q        <= ptr_d;
            type_q       <= type_d;
            str_id_q     <= str_id_d;
            pat_id_q     <= pat_id_d;
            in_ready_q   <= in_ready_d;
            chardata_q   <= chardata_d;
            isstring_q   <= isstring_d;
            ispattern_q  <= ispattern_d;
            res_valid_q  <= res_valid_d;
            res_match_q  <= res_match_d;
            res_index_q  <= res_index_d;
            res_str_id_q <= res_str_id_d;
            res_pat_id_q <= res_pat_id_d;
            ovf_q        <= ovf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        ptr_d        = ptr_q;
        type_d       = type_q;
        str_id_d     = str_id_q;
        pat_id_d     = pat_id_q;
        chardata_d   = chardata_q;
        isstring_d   = 1'b0;
        ispattern_d  = 1'b0;
        res_valid_d  = res_valid_q;
        res_match_d  = res_match_q;
        res_index_d  = res_index_q;
        res_str_id_d = res_str_id_q;
        res_pat_id_d = res_pat_id_q;
        ovf_d        = ovf_q;
        we_c         = 1'b0;
        waddr_c      = AW'(len_q);

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    type_d  = in_type;
                    we_c    = 1'b1;
                    waddr_c = '0;
                    len_d   = LEN_W'(1);
                    state_d = in_last ? ST_PLAY : ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Characters beyond the per-type limit are dropped and flagged.
                if (accept_c) begin
                    if (len_q < limit_c) begin
                        we_c  = 1'b1;
                        len_d = len_q + LEN_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = ST_PLAY;
                    end
                end
            end
            ST_PLAY: begin
                chardata_d  = mem_q[ptr_q];
                isstring_d  = ~type_q;
                ispattern_d = type_q;
                if (play_last_c) begin
                    ptr_d = '0;
                    if (type_q) begin
                        state_d = ST_WAIT;
                    end else begin
                        str_id_d = str_id_q + ID_W'(1);
                        pat_id_d = '0;
                        state_d  = ST_IDLE;
                    end
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            ST_WAIT: begin
                if (sme_valid) begin
                    res_match_d  = sme_match;
                    res_index_d  = sme_match_index;
                    res_str_id_d = str_id_q;
                    res_pat_id_d = pat_id_q;
                    res_valid_d  = 1'b1;
                    state_d      = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    pat_id_d    = pat_id_q + ID_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    end

    assign in_ready   = in_ready_q;
    assign chardata   = chardata_q;
    assign isstring   = isstring_q;
    assign ispattern  = ispattern_q;
    assign res_valid  = res_valid_q;
    assign res_match  = res_match_q;
    assign res_index  = res_index_q;
    assign res_str_id = res_str_id_q;
    assign res_pat_id = res_pat_id_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_sme_feeder.sv
// Directed bench for sme_feeder: scoreboarded burst beats and tagged results.
module tb_sme_feeder;

    localparam int MAX_STR = 32;
    localparam int MAX_PAT = 8;
    localparam int ID_W    = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      in_data;
    logic            in_type;
    logic            in_last;
    logic [7:0]      chardata;
    logic            isstring;
    logic            ispattern;
    logic            sme_valid;
    logic            sme_match;
    logic [4:0]      sme_match_index;
    logic            res_valid;
    logic            res_ready;
    logic            res_match;
    logic [4:0]      res_index;
    logic [ID_W-1:0] res_str_id;
    logic [ID_W-1:0] res_pat_id;
    logic            ovf;

    int checks = 0;
    int errors = 0;
    int str_cnt = 0;
    int pat_cnt = 0;
    int run = 0;

    logic [9:0]  exp_q [$];
    int          blen_q [$];
    logic [13:0] res_q [$];
    logic [7:0]  rec [$];

    sme_feeder #(
        .MAX_STR_LEN(MAX_STR),
        .MAX_PAT_LEN(MAX_PAT),
        .ID_W(ID_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_type(in_type),
        .in_last(in_last),
        .chardata(chardata),
        .isstring(isstring),
        .ispattern(ispattern),
        .sme_valid(sme_valid),
        .sme_match(sme_match),
        .sme_match_index(sme_match_index),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_match(res_match),
        .res_index(res_index),
        .res_str_id(res_str_id),
        .res_pat_id(res_pat_id),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rec(input string s);
        rec.delete();
        for (int i = 0; i < s.len(); i++) rec.push_back(8'(s[i]));
    endtask

    // Drives rec[] as one record; expected burst beats are queued up front.
    task automatic send_rec(input logic typ, input bit rnd, input bit wait_burst);
        int n, lim, neff, to;
        n    = rec.size();
        lim  = typ ? MAX_PAT : MAX_STR;
        neff = (n < lim) ? n : lim;
        for (int i = 0; i < neff; i++) exp_q.push_back({~typ, typ, rec[i]});
        blen_q.push_back(neff);
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                while ($urandom_range(1) == 0) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = rec[i];
            in_type  = typ;
            in_last  = (i == n - 1);
            to = 0;
            while (!in_ready && to < 100) begin
                @(negedge clk);
                to++;
            end
            if (to >= 100) check("in_ready_timeout", 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!typ) begin
            str_cnt++;
            pat_cnt = 0;
        end
        if (wait_burst) begin
            @(negedge clk);
            check("burst_start", {isstring, ispattern}, {~typ, typ});
            check("burst_first_char", chardata, rec[0]);
            repeat (neff) @(negedge clk);
            check("burst_end", {isstring, ispattern}, 2'b00);
        end
    endtask

    task automatic sme_respond(input int delay, input logic m, input logic [4:0] idx);
        check("in_ready_in_wait", in_ready, 1'b0);
        repeat (delay) @(negedge clk);
        check("res_valid_before_sme", res_valid, 1'b0);
        sme_valid       = 1'b1;
        sme_match       = m;
        sme_match_index = idx;
        res_q.push_back({m, idx, 4'(str_cnt), 4'(pat_cnt)});
        @(negedge clk);
        sme_valid       = 1'b0;
        sme_match       = 1'b0;
        sme_match_index = '0;
    endtask

    task automatic get_result(input int hold, input bit poke);
        int to;
        logic [13:0] e;
        to = 0;
        while (!res_valid && to < 100) begin
            @(negedge clk);
            to++;
        end
        if (to >= 100) check("res_valid_timeout", 32'(res_valid), 32'd1);
        if (res_q.size() == 0) begin
            check("res_unexpected", 32'(res_valid), 32'd0);
        end else begin
            e = res_q.pop_front();
            check("res_fields", {res_match, res_index, res_str_id, res_pat_id}, e);
            // Downstream stalls: result must hold and no new record may enter.
            for (int i = 0; i < hold; i++) begin
                in_valid = poke;
                in_data  = 8'h7a;
                in_type  = 1'b0;
                in_last  = 1'b1;
                @(negedge clk);
                check("in_ready_while_pending", in_ready, 1'b0);
                check("res_stable", {res_valid, res_match, res_index, res_str_id, res_pat_id}, {1'b1, e});
            end
            in_valid  = 1'b0;
            in_last   = 1'b0;
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            check("res_valid_drop", res_valid, 1'b0);
            pat_cnt++;
        end
    endtask

    // Scoreboard monitor: every burst beat is popped and compared; run lengths checked.
    always @(negedge clk) begin
        if (!reset) begin
            run = 0;
        end else if (isstring || ispattern) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL burst_extra: observed %0h expected none", {isstring, ispattern, chardata});
            end else begin
                check("burst_beat", {isstring, ispattern, chardata}, exp_q.pop_front());
            end
            run++;
        end else if (run != 0) begin
            if (blen_q.size() == 0) check("burst_len_unexpected", run, 0);
            else check("burst_len", run, blen_q.pop_front());
            run = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b0;
        in_valid        = 1'b0;
        in_data         = '0;
        in_type         = 1'b0;
        in_last         = 1'b0;
        sme_valid       = 1'b0;
        sme_match       = 1'b0;
        sme_match_index = '0;
        res_ready       = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_flags", {isstring, ispattern, res_valid, res_match, ovf}, 5'b0);
        check("rst_data", {chardata, res_index, res_str_id, res_pat_id}, '0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1'b1);

        // String "abc"
        set_rec("abc");
        send_rec(1'b0, 1'b0, 1'b1);

        // sme_valid outside WAIT is ignored
        sme_valid = 1'b1;
        sme_match = 1'b1;
        @(negedge clk);
        sme_valid = 1'b0;
        sme_match = 1'b0;
        @(negedge clk);
        check("sme_valid_ignored", res_valid, 1'b0);

        // String "hello" then pattern "ll"
        set_rec("hello");
        send_rec(1'b0, 1'b0, 1'b1);
        set_rec("ll");
        send_rec(1'b1, 1'b0, 1'b1);
        sme_respond(5, 1'b1, 5'd2);
        get_result(0, 1'b0);

        // Two patterns on the same string, first result stalled
        set_rec("he");
        send_rec(1'b1, 1'b0, 1'b1);
        sme_respond(3, 1'b1, 5'd0);
        get_result(10, 1'b1);
        set_rec("xyz");
        send_rec(1'b1, 1'b0, 1'b1);
        sme_respond(1, 1'b0, 5'd0);
        get_result(0, 1'b0);

        // Over-long pattern truncates to MAX_PAT characters
        check("ovf_before", ovf, 1'b0);
        set_rec("0123456789");
        send_rec(1'b1, 1'b0, 1'b1);
        check("ovf_after", ovf, 1'b1);
        sme_respond(2, 1'b0, 5'd31);
        get_result(0, 1'b0);

        // Full-length string with ragged in_valid
        rec.delete();
        for (int i = 0; i < MAX_STR; i++) rec.push_back(8'(8'h41 + i));
        send_rec(1'b0, 1'b1, 1'b1);

        // Reset during the 4th replay cycle
        set_rec("abcdefgh");
        send_rec(1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("pre_reset_char", chardata, 8'h64);
        #2 reset = 1'b0;
        #1;
        check("reset_isstring", {isstring, ispattern}, 2'b00);
        check("reset_chardata", chardata, 8'h00);
        check("reset_in_ready", in_ready, 1'b0);
        exp_q.delete();
        blen_q.delete();
        str_cnt = 0;
        pat_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("reset_ovf_cleared", ovf, 1'b0);

        // Pattern before any string, then a fresh string and pattern
        set_rec("q");
        send_rec(1'b1, 1'b0, 1'b1);
        sme_respond(2, 1'b0, 5'd7);
        get_result(0, 1'b0);
        set_rec("ok");
        send_rec(1'b0, 1'b0, 1'b1);
        set_rec("k");
        send_rec(1'b1, 1'b0, 1'b1);
        sme_respond(4, 1'b1, 5'd1);
        get_result(0, 1'b0);

        repeat (3) @(negedge clk);
        check("beats_drained", exp_q.size(), 0);
        check("bursts_drained", blen_q.size(), 0);
        check("results_drained", res_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
